mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one
// single-ported synchronous memory. One transaction per two cycles, with
// alternating priority under contention and out-of-range error responses.
module mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  // what the response cycle needs to remember about the granted access
  typedef struct packed {
    logic err;
    logic we;
  } pend_t;

  state_t state, state_nxt;
  logic   last_d, last_d_nxt;   // 1: most recent grant went to the data port
  pend_t  pend, pend_nxt;

  logic   if_inr, d_inr;
  logic   pick_d, pick_if;
  logic   unused_lsb;

  // byte offset within a word plays no role; word accesses only
  assign unused_lsb = ^{if_addr[1:0], d_addr[1:0]};

  assign if_inr = (if_addr[31:ADDR_W+2] == '0);
  assign d_inr  = (d_addr[31:ADDR_W+2] == '0);

  // under contention, serve whichever port did not win last time
  assign pick_d  = d_req && (!if_req || !last_d);
  assign pick_if = if_req && !pick_d;

  // arbitration, memory strobes and response muxing; rst masks everything
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    pend_nxt   = pend;
    if_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    if_err     = 1'b0;
    d_gnt      = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    d_err      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            d_gnt      = 1'b1;
            state_nxt  = BUSY_D;
            last_d_nxt = 1'b1;
            pend_nxt   = '{err: !d_inr, we: d_we};
            if (d_inr) begin
              mem_en    = 1'b1;
              mem_we    = d_we;
              mem_addr  = d_addr[ADDR_W+1:2];
              mem_be    = d_be;
              mem_wdata = d_wdata;
            end
          end else if (pick_if) begin
            if_gnt     = 1'b1;
            state_nxt  = BUSY_IF;
            last_d_nxt = 1'b0;
            pend_nxt   = '{err: !if_inr, we: 1'b0};
            if (if_inr) begin
              mem_en   = 1'b1;
              mem_addr = if_addr[ADDR_W+1:2];
            end
          end
        end
        BUSY_IF: begin
          if_rvalid = 1'b1;
          if_err    = pend.err;
          if_rdata  = pend.err ? '0 : mem_rdata;
          state_nxt = IDLE;
        end
        BUSY_D: begin
          d_rvalid  = 1'b1;
          d_err     = pend.err;
          d_rdata   = (pend.err || pend.we) ? '0 : mem_rdata;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // state, priority flag and pending-response bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
      pend   <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      pend   <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, reference memory image and
// per-port response queues checked on the falling edge.
module tb_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0] d_be;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] envmem [DEPTH];
  logic [31:0] refmem [DEPTH];

  // behavioural memory; rdata is garbage on cycles that follow no read
  always @(posedge clk) begin : memmodel
    logic [31:0] w;
    if (mem_en && mem_we) begin
      w = envmem[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      envmem[mem_addr] <= w;
    end
    if (mem_en && !mem_we) mem_rdata <= envmem[mem_addr];
    else                   mem_rdata <= $urandom;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", tag, act, exp, cyc);
    end
  endtask

  typedef struct {logic [31:0] data; logic err; int due;} exp_t;
  typedef struct {bit isd; int cyc;} gnt_t;
  exp_t iq[$];
  exp_t dq[$];
  gnt_t glog[$];
  bit   last_d = 1'b0;

  function automatic bit inr(input logic [31:0] a);
    return a[31:ADDR_W+2] == '0;
  endfunction

  // response scoreboard plus idle-zero and reset checks
  always @(negedge clk) begin
    if (rst) begin
      iq.delete();
      dq.delete();
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_strobes", {if_gnt, d_gnt, mem_en, mem_we}, 0);
    end else begin
      if (iq.size() > 0 && iq[0].due == cyc) begin
        chk("if_rvalid", if_rvalid, 1);
        chk("if_rdata", if_rdata, iq[0].data);
        chk("if_err", if_err, iq[0].err);
        chk("if_busy_quiet", {if_gnt, d_gnt, mem_en}, 0);
        void'(iq.pop_front());
      end else begin
        chk("if_rvalid_idle", if_rvalid, 0);
        chk("if_rsp_idle", {if_rdata, if_err}, 0);
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        chk("d_rvalid", d_rvalid, 1);
        chk("d_rdata", d_rdata, dq[0].data);
        chk("d_err", d_err, dq[0].err);
        chk("d_busy_quiet", {if_gnt, d_gnt, mem_en}, 0);
        void'(dq.pop_front());
      end else begin
        chk("d_rvalid_idle", d_rvalid, 0);
        chk("d_rsp_idle", {d_rdata, d_err}, 0);
      end
    end
  end

  // call at posedge+1; returns at posedge+1 of the cycle after the grant
  task automatic fetch(input logic [31:0] a);
    int   n = 0;
    bit   ok = 0;
    exp_t e;
    gnt_t g;
    if_req = 1'b1;
    if_addr = a;
    while (n < 50 && !ok) begin
      @(negedge clk);
      if (if_gnt) ok = 1; else n++;
    end
    if (!ok) chk("if_gnt_timeout", 0, 1);
    else begin
      chk("if_excl", d_gnt, 0);
      chk("if_mem_en", mem_en, inr(a));
      if (inr(a)) chk("if_mem_addr", mem_addr, a[ADDR_W+1:2]);
      chk("if_mem_we_be", {mem_we, mem_be}, 0);
      e.data = inr(a) ? refmem[a[ADDR_W+1:2]] : 32'h0;
      e.err  = !inr(a);
      e.due  = cyc + 1;
      iq.push_back(e);
      g.isd = 0; g.cyc = cyc;
      glog.push_back(g);
      last_d = 0;
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dop(input bit we, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd);
    int   n = 0;
    bit   ok = 0;
    exp_t e;
    gnt_t g;
    logic [31:0] w;
    logic [ADDR_W-1:0] idx;
    idx = a[ADDR_W+1:2];
    d_req = 1'b1; d_we = we; d_addr = a; d_be = be; d_wdata = wd;
    while (n < 50 && !ok) begin
      @(negedge clk);
      if (d_gnt) ok = 1; else n++;
    end
    if (!ok) chk("d_gnt_timeout", 0, 1);
    else begin
      chk("d_excl", if_gnt, 0);
      chk("d_mem_en", mem_en, inr(a));
      if (inr(a)) begin
        chk("d_mem_addr", mem_addr, idx);
        chk("d_mem_we", mem_we, we);
        chk("d_mem_be", mem_be, be);
        if (we) chk("d_mem_wdata", mem_wdata, wd);
      end else begin
        chk("d_oor_mem_we", mem_we, 0);
      end
      if (inr(a) && we) begin
        w = refmem[idx];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        refmem[idx] = w;
      end
      e.data = (!inr(a) || we) ? 32'h0 : refmem[idx];
      e.err  = !inr(a);
      e.due  = cyc + 1;
      dq.push_back(e);
      g.isd = 1; g.cyc = cyc;
      glog.push_back(g);
      last_d = 1;
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic quiet_outs(input string tag);
    @(negedge clk);
    chk(tag, {if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err,
              mem_en, mem_we, mem_be, mem_addr}, 0);
    chk({tag, "_data"}, {if_rdata ^ d_rdata} | mem_wdata, 0);
    @(posedge clk); #1;
  endtask

  // both ports request in the same IDLE cycle; priority follows last grant
  task automatic contend(input string tag);
    int c0;
    bit first_d;
    c0 = cyc;
    first_d = !last_d;
    glog.delete();
    fork
      fetch(32'h8);
      dop(0, 32'h10, 4'hf, 32'h0);
    join
    chk({tag, "_n"}, glog.size(), 2);
    if (glog.size() == 2) begin
      chk({tag, "_first"}, glog[0].isd, first_d);
      chk({tag, "_first_cyc"}, glog[0].cyc, c0);
      chk({tag, "_second"}, glog[1].isd, !first_d);
      chk({tag, "_second_cyc"}, glog[1].cyc, c0 + 2);
    end
    idle();
  endtask

  // reset during the response cycle of a fresh grant
  task automatic rst_mid(input bit isd);
    if (isd) begin d_req = 1; d_we = 0; d_addr = 32'h20; d_be = 4'hf; end
    else begin if_req = 1; if_addr = 32'h8; end
    @(negedge clk);
    chk("rm_gnt", isd ? d_gnt : if_gnt, 1);
    @(posedge clk); #1;
    if_req = 0; d_req = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    last_d = 0;
    quiet_outs("rm_outs");
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
    return a;
  endfunction

  initial begin
    int c0;
    bit ld;
    for (int i = 0; i < DEPTH; i++) begin
      envmem[i] = 32'h5a5a_0000 ^ (i * 32'h0001_0203);
      refmem[i] = envmem[i];
    end
    envmem[2] = 32'h0030_0193;
    refmem[2] = 32'h0030_0193;
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    quiet_outs("post_rst");

    // first contention after reset goes to data
    contend("cont_rst");
    // fetch alone; word 2 preloaded
    fetch(32'h8); idle();
    // partial write then read-back
    dop(1, 32'h14, 4'b0011, 32'hDEAD_BEEF); idle();
    dop(0, 32'h14, 4'hf, 32'h0); idle();
    // out-of-range read, write (must not alias word 0) and fetch
    dop(0, 32'h1000, 4'hf, 32'h0); idle();
    dop(1, 32'h1000, 4'hf, 32'hFFFF_FFFF); idle();
    dop(0, 32'h0, 4'hf, 32'h0); idle();
    fetch(32'hFFFF_FFF0); idle();
    // top in-range word with ignored low bits
    fetch(32'h0000_0FFF); idle();

    // sustained contention: four requests per port back to back
    glog.delete();
    c0 = cyc;
    ld = last_d;
    fork
      begin repeat (4) fetch(32'($urandom_range(0, 1023)) << 2); end
      begin repeat (4) dop(0, 32'($urandom_range(0, 1023)) << 2, 4'hf, 32'h0); end
    join
    chk("sus_n", glog.size(), 8);
    if (glog.size() == 8)
      for (int k = 0; k < 8; k++) begin
        chk("sus_type", glog[k].isd, (!ld) ^ k[0]);
        chk("sus_cyc", glog[k].cyc, c0 + 2 * k);
      end
    idle();

    // random mix
    repeat (40) begin
      case ($urandom_range(0, 2))
        0: fetch(raddr());
        1: dop($urandom_range(0, 1), raddr(), 4'($urandom), $urandom);
        default: fork
          fetch(raddr());
          dop($urandom_range(0, 1), raddr(), 4'($urandom), $urandom);
        join
      endcase
      idle();
    end

    // reset in BUSY_IF and BUSY_D; flag must be back to fetch afterwards
    rst_mid(0);
    contend("cont_rif");
    rst_mid(1);
    contend("cont_rd");

    repeat (3) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
